// File: rtl/pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : pixel_dispatcher
// Purpose  : Walks the pixel coordinates of one Mandelbrot frame in row-major
//            order and hands each pixel job to one of NUM_ENGINES iteration
//            engines, chosen by round-robin arbitration over their idle
//            requests. Jobs still in flight are tracked, and completion of
//            the whole frame is reported to the frame-buffer/VGA control.
// Ports    : clock        - system clock, rising edge
//            reset        - asynchronous active-high reset
//            start        - begin a frame (accepted only while idle)
//            abort        - stop dispatching (honoured only while dispatching)
//            eng_req      - per-engine "idle, ready for a job"
//            eng_done     - per-engine 1-cycle "job finished" pulse
//            grant        - one-hot 1-cycle pulse, owner of job_*
//            job_row/col  - pixel coordinates, valid while grant != 0
//            job_idx      - linear index row*MAXCOL+col, valid while grant != 0
//            busy         - high while dispatching or draining
//            frame_done   - 1-cycle pulse when a non-aborted frame completes
//            outstanding  - jobs granted and not yet reported done
//            frame_cycles - busy-cycle count of the last frame
//                           (present only with DISPATCH_CYCLE_COUNT_EN)
// Options  : `define DISPATCH_CYCLE_COUNT_EN adds the frame_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_dispatcher #(
    parameter int MAXROW      = 300,
    parameter int MAXCOL      = 400,
    parameter int NUM_ENGINES = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic [NUM_ENGINES-1:0]             eng_req,
    input  logic [NUM_ENGINES-1:0]             eng_done,
    output logic [NUM_ENGINES-1:0]             grant,
    output logic [31:0]                        job_row,
    output logic [31:0]                        job_col,
    output logic [31:0]                        job_idx,
    output logic                               busy,
    output logic                               frame_done,
`ifdef DISPATCH_CYCLE_COUNT_EN
    output logic [31:0]                        frame_cycles,
`endif
    output logic [$clog2(NUM_ENGINES+1)-1:0]   outstanding
);

    localparam int c_max_idx  = MAXROW * MAXCOL;
    localparam int c_ow       = $clog2(NUM_ENGINES + 1);
    localparam int c_pw       = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int c_sw       = c_pw + 1;
    localparam int c_cw       = c_ow + 1;
    localparam logic [31:0] c_last_idx = 32'(c_max_idx - 1);
    localparam logic [31:0] c_last_col = 32'(MAXCOL - 1);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_dispatch = 2'd1;
    localparam logic [1:0] c_st_drain    = 2'd2;

    logic [1:0]             r_state;
    logic [31:0]            r_row;
    logic [31:0]            r_col;
    logic [31:0]            r_idx;
    logic [c_pw-1:0]        r_ptr;
    logic                   r_aborted;

    logic [NUM_ENGINES-1:0] w_req_masked;
    logic [NUM_ENGINES-1:0] w_req_rot;
    logic                   w_found;
    logic [c_sw-1:0]        w_off;
    logic [c_sw-1:0]        w_sum;
    logic [c_pw-1:0]        w_sel;
    logic [c_pw-1:0]        w_ptr_next;
    logic [NUM_ENGINES-1:0] w_grant_oh;
    logic [c_cw-1:0]        w_done_cnt;
    logic [c_cw-1:0]        w_up;
    logic [c_cw-1:0]        w_net;
    logic [c_ow-1:0]        w_out_next;

    // An engine that was granted this cycle may still show its request for
    // one more cycle; masking it avoids handing it a second job.
    assign w_req_masked = eng_req & ~grant;

    // Rotate so that bit 0 corresponds to the engine at the pointer; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign w_req_rot = NUM_ENGINES'({w_req_masked, w_req_masked} >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_found = 1'b1;
                w_off   = c_sw'(k);
            end
        end
    end

    assign w_sum      = {1'b0, r_ptr} + w_off;
    assign w_sel      = (w_sum >= c_sw'(NUM_ENGINES)) ? c_pw'(w_sum - c_sw'(NUM_ENGINES))
                                                      : c_pw'(w_sum);
    assign w_ptr_next = (w_sel == c_pw'(NUM_ENGINES - 1)) ? '0 : w_sel + c_pw'(1);
    assign w_grant_oh = NUM_ENGINES'(1) << w_sel;

    always_comb begin
        w_done_cnt = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (eng_done[k]) begin
                w_done_cnt = w_done_cnt + c_cw'(1);
            end
        end
    end

    // Net the job handed out this cycle against the completions; completions
    // beyond what is in flight (e.g. stale ones after a reset) are dropped.
    assign w_up  = c_cw'(outstanding) + c_cw'(|grant);
    assign w_net = (w_done_cnt >= w_up) ? '0 : (w_up - w_done_cnt);
    assign w_out_next = (w_net > c_cw'(NUM_ENGINES)) ? c_ow'(NUM_ENGINES) : c_ow'(w_net);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_row       <= '0;
            r_col       <= '0;
            r_idx       <= '0;
            r_ptr       <= '0;
            r_aborted   <= 1'b0;
            grant       <= '0;
            job_row     <= '0;
            job_col     <= '0;
            job_idx     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            outstanding <= '0;
        end else begin
            grant       <= '0;
            frame_done  <= 1'b0;
            outstanding <= w_out_next;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state   <= c_st_dispatch;
                        busy      <= 1'b1;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_idx     <= '0;
                        r_aborted <= 1'b0;
                    end
                end
                c_st_dispatch: begin
                    if (abort) begin
                        r_state   <= c_st_drain;
                        r_aborted <= 1'b1;
                    end else if (w_found) begin
                        grant   <= w_grant_oh;
                        job_row <= r_row;
                        job_col <= r_col;
                        job_idx <= r_idx;
                        r_ptr   <= w_ptr_next;
                        r_idx   <= r_idx + 32'd1;
                        if (r_col == c_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + 32'd1;
                        end else begin
                            r_col <= r_col + 32'd1;
                        end
                        if (r_idx == c_last_idx) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    // A grant still on the output has not yet been counted
                    // into outstanding, so wait for it as well.
                    if (outstanding == '0 && grant == '0) begin
                        r_state    <= c_st_idle;
                        busy       <= 1'b0;
                        frame_done <= ~r_aborted;
                        r_aborted  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef DISPATCH_CYCLE_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cycles <= '0;
        end else if (r_state == c_st_idle && start) begin
            frame_cycles <= '0;
        end else if (busy && frame_cycles != 32'hFFFF_FFFF) begin
            frame_cycles <= frame_cycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
